regfile_sp: RTL and testbench
=============================

# regfile_sp

Parametrised register file for the pipelined processor, with a dedicated stack-pointer register that has bounded increment/decrement and sticky stack fault flags. It replaces the fixed 4×8 register file in the decode/write-back path. It adds:
- configurable width and depth;
- optional write-to-read bypass;
- asynchronous reset to defined values;
- a defined response to every SP collision case.

Reads are combinational. State updates on the falling clock edge, so a write-back in the first half-cycle is visible to decode in the second half.

## Interface
- DATA_W, 8: register width in bits.
- ADDR_W, 2: address width. Register count NREGS = 2**ADDR_W.
- SP_IDX, NREGS-1: index of the stack-pointer register.
- SP_RESET, 2**DATA_W-1: SP value after reset.
- SP_MIN, 0: lowest legal SP. A DecSP at or below this value is blocked.
- SP_MAX, 2**DATA_W-1: highest legal SP. An IncSP at or above this value is blocked.
- BYPASS, 0: 1 = a read of the address being written returns WD combinationally.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on negedge.
- rst  in  1  asynchronous, active-high reset.
- WE  in  1  write enable from write-back.
- RW_addr  in  ADDR_W  write address.
- WD  in  DATA_W  write data.
- IncSP  in  1  SP+1 request (POP/RET/RTI).
- DecSP  in  1  SP-1 request (PUSH/CALL/interrupt).
- clr_flags  in  1  clears stack_ovf and stack_unf.
- RA_addr, RB_addr  in  ADDR_W each  read addresses.
- RD_A, RD_B  out  DATA_W each  read data.
- SP_out  out  DATA_W  current SP register value, never bypassed.
- stack_ovf  out  1  sticky: a DecSP was blocked at SP_MIN.
- stack_unf  out  1  sticky: an IncSP was blocked at SP_MAX.

## Operation
- **Reset (rst high):** immediately and for as long as rst is held:
  - every non-SP register = 0;
  - SP = SP_RESET;
  - stack_ovf = stack_unf = 0.
  - Reset overrides all inputs.
- **Read path:**
  - RD_A = file[RA_addr]; RD_B = file[RB_addr].
  - If BYPASS=1, WE=1 and RW_addr equals the read address, that port returns WD instead.
- **Write to a non-SP register:** on negedge with WE=1 and RW_addr != SP_IDX, file[RW_addr] <= WD. SP adjustment proceeds in parallel on the same edge.
- **Write to SP:** WE=1 and RW_addr == SP_IDX.
  - SP <= WD with no range check.
  - IncSP/DecSP on that edge are discarded and no flags are set.
- **SP adjust:** applies when there is no SP write, evaluated on the current SP value (unsigned).
  - DecSP=1, IncSP=0:
    - if SP > SP_MIN, SP <= SP-1;
    - otherwise SP is unchanged and stack_ovf <= 1.
  - IncSP=1, DecSP=0:
    - if SP < SP_MAX, SP <= SP+1;
    - otherwise SP is unchanged and stack_unf <= 1.
  - IncSP=1 and DecSP=1: SP unchanged, no flag change (net zero).
- **Flags:**
  - Sticky until clr_flags=1 on a negedge or until reset.
  - If a set event and clr_flags occur on the same edge, set wins.
- **Arithmetic:** SP never wraps, because the bound checks block it. SP values outside [SP_MIN, SP_MAX] can only come from a direct write; a later adjust is then blocked in the out-of-range direction and flagged.

## Timing
- Read latency: 0 cycles (combinational).
- Write / SP-adjust latency: visible on RD_* and SP_out immediately after the negedge at which it is applied.
- No handshakes. Every request is consumed on the negedge at which it is sampled. Requests must be stable around the negedge.
- rst asserted mid-cycle: outputs take reset values immediately. Inputs are ignored until the first negedge after rst deasserts.
- With BYPASS=0, a read of the address being written returns the old value until the negedge.

## Test plan
- **Reset:** write R0=0x5A, then pulse rst mid-cycle.
  - Expect RD of R0 = 0x00, SP_out = 0xFF, both flags 0, all without waiting for a clock edge.
- **Push/pop sequence from SP = 0xFF:**
  - DecSP for 3 negedges → SP_out = 0xFC.
  - IncSP for 3 negedges → SP_out = 0xFF.
  - IncSP once more → SP_out stays 0xFF, stack_unf = 1.
  - clr_flags → stack_unf = 0.
- **Overflow:** WE writes SP=0x01, then DecSP for 2 negedges.
  - Expect SP_out = 0x00 and stack_ovf = 1 after the second edge.
  - Same edge with clr_flags=1 and another blocked DecSP → stack_ovf stays 1.
- **Collisions, SP = 0x80:**
  - WE to SP with WD=0x40 and DecSP=1 → SP = 0x40, no flag.
  - WE to R1 with WD=0x11 and DecSP=1 → R1 = 0x11 and SP = 0x3F.
  - IncSP and DecSP both asserted → SP unchanged.
- **Bypass:**
  - BYPASS=1: WE, RW_addr=2, WD=0x77, RA_addr=2 → RD_A = 0x77 before the negedge.
  - BYPASS=0: RD_A shows the old value until the negedge, then 0x77.
  - SP_out is never bypassed in either case.
- **Parameter sweep:** DATA_W=16, ADDR_W=3, SP_IDX=7, SP_MIN=0x0100, SP_MAX=0x01FF, SP_RESET=0x01FF.
  - Reset → SP_out = 0x01FF.
  - DecSP ×256 → SP_out = 0x00FF... not reachable: SP stops at 0x0100 after 255 decrements, and the 256th DecSP sets stack_ovf.
  - Write/read all 8 registers with distinct values and check each one.

Source files
------------

// File: rtl/regfile_sp.sv
// Register file with combinational reads, negedge updates and a bounded stack pointer.
// The stack pointer lives in the file at SP_IDX and also drives SP_out directly.
module regfile_sp #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 2,
  parameter int                SP_IDX   = (1 << ADDR_W) - 1,
  parameter logic [DATA_W-1:0] SP_RESET = '1,
  parameter logic [DATA_W-1:0] SP_MIN   = '0,
  parameter logic [DATA_W-1:0] SP_MAX   = '1,
  parameter bit                BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RW_addr,
  input  logic [DATA_W-1:0] WD,
  input  logic              IncSP,
  input  logic              DecSP,
  input  logic              clr_flags,
  input  logic [ADDR_W-1:0] RA_addr,
  input  logic [ADDR_W-1:0] RB_addr,
  output logic [DATA_W-1:0] RD_A,
  output logic [DATA_W-1:0] RD_B,
  output logic [DATA_W-1:0] SP_out,
  output logic              stack_ovf,
  output logic              stack_unf
);
  localparam int                NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_IDX);

  logic [NREGS-1:0][DATA_W-1:0] r_file;
  logic                         r_ovf, r_unf;
  logic                         w_sp_wr;
  logic [DATA_W-1:0]            w_sp, w_sp_nxt;
  logic                         w_ovf_set, w_unf_set;

  assign w_sp    = r_file[SP_IDX];
  assign w_sp_wr = WE && (RW_addr == SP_A);

  // Direct SP write takes priority; adjust only runs otherwise and never wraps.
  always_comb begin
    w_sp_nxt  = w_sp;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (w_sp_wr) begin
      w_sp_nxt = WD;
    end else if (DecSP && !IncSP) begin
      if (w_sp > SP_MIN) w_sp_nxt  = w_sp - 1'b1;
      else               w_ovf_set = 1'b1;
    end else if (IncSP && !DecSP) begin
      if (w_sp < SP_MAX) w_sp_nxt  = w_sp + 1'b1;
      else               w_unf_set = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_file[i] <= '0;
      r_file[SP_IDX] <= SP_RESET;
      r_ovf          <= 1'b0;
      r_unf          <= 1'b0;
    end else begin
      if (WE && !w_sp_wr) r_file[RW_addr] <= WD;
      r_file[SP_IDX] <= w_sp_nxt;
      // A set on the same edge as a clear wins.
      r_ovf <= w_ovf_set | (r_ovf & ~clr_flags);
      r_unf <= w_unf_set | (r_unf & ~clr_flags);
    end
  end

  assign RD_A      = (BYPASS && WE && (RW_addr == RA_addr)) ? WD : r_file[RA_addr];
  assign RD_B      = (BYPASS && WE && (RW_addr == RB_addr)) ? WD : r_file[RB_addr];
  assign SP_out    = w_sp;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;
endmodule

// File: tb/tb_regfile_sp.sv
// Directed bench for regfile_sp: 8-bit file with and without bypass, plus a 16-bit bounded-SP variant.
module tb_regfile_sp;
  logic        clk = 1'b1;
  logic        rst, WE, IncSP, DecSP, clr_flags;
  logic [2:0]  rw, ra, rb;
  logic [15:0] wd;
  logic [7:0]  a0, b0, sp0, a1, b1, sp1;
  logic        ovf0, unf0, ovf1, unf1, ovf2, unf2;
  logic [15:0] a2, b2, sp2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  regfile_sp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .WE(WE), .RW_addr(rw[1:0]), .WD(wd[7:0]),
    .IncSP(IncSP), .DecSP(DecSP), .clr_flags(clr_flags),
    .RA_addr(ra[1:0]), .RB_addr(rb[1:0]), .RD_A(a0), .RD_B(b0),
    .SP_out(sp0), .stack_ovf(ovf0), .stack_unf(unf0));

  regfile_sp #(.BYPASS(1'b1)) u_bp (
    .clk(clk), .rst(rst), .WE(WE), .RW_addr(rw[1:0]), .WD(wd[7:0]),
    .IncSP(IncSP), .DecSP(DecSP), .clr_flags(clr_flags),
    .RA_addr(ra[1:0]), .RB_addr(rb[1:0]), .RD_A(a1), .RD_B(b1),
    .SP_out(sp1), .stack_ovf(ovf1), .stack_unf(unf1));

  regfile_sp #(.DATA_W(16), .ADDR_W(3), .SP_IDX(7), .SP_MIN(16'h0100),
               .SP_MAX(16'h01FF), .SP_RESET(16'h01FF)) u_w16 (
    .clk(clk), .rst(rst), .WE(WE), .RW_addr(rw), .WD(wd),
    .IncSP(IncSP), .DecSP(DecSP), .clr_flags(clr_flags),
    .RA_addr(ra), .RB_addr(rb), .RD_A(a2), .RD_B(b2),
    .SP_out(sp2), .stack_ovf(ovf2), .stack_unf(unf2));

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    WE = 0; IncSP = 0; DecSP = 0; clr_flags = 0;
  endtask

  task automatic test_reset();
    idle(); rw = 0; ra = 0; rb = 1; wd = 0;
    rst = 1; #12; rst = 0; #1;
    WE = 1; rw = 0; wd = 16'h5A; step(); WE = 0;
    checks++; if (a0 !== 8'h5A) begin failures++; $display("FAIL wr_r0 got=%h exp=5a", a0); end
    #2 rst = 1; #1;
    checks++; if (a0 !== 8'h00) begin failures++; $display("FAIL rst_r0 got=%h exp=00", a0); end
    checks++; if (sp0 !== 8'hFF) begin failures++; $display("FAIL rst_sp got=%h exp=ff", sp0); end
    checks++; if ({ovf0, unf0} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {ovf0, unf0}); end
    #1 rst = 0;
    step();
  endtask

  task automatic test_push_pop();
    idle(); DecSP = 1; repeat (3) step();
    checks++; if (sp0 !== 8'hFC) begin failures++; $display("FAIL push3 got=%h exp=fc", sp0); end
    DecSP = 0; IncSP = 1; repeat (3) step();
    checks++; if (sp0 !== 8'hFF) begin failures++; $display("FAIL pop3 got=%h exp=ff", sp0); end
    step();
    checks++; if (sp0 !== 8'hFF) begin failures++; $display("FAIL pop_blk got=%h exp=ff", sp0); end
    checks++; if (unf0 !== 1'b1) begin failures++; $display("FAIL unf_set got=%b exp=1", unf0); end
    IncSP = 0; step();
    checks++; if (unf0 !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", unf0); end
    clr_flags = 1; step(); clr_flags = 0;
    checks++; if (unf0 !== 1'b0) begin failures++; $display("FAIL unf_clr got=%b exp=0", unf0); end
  endtask

  task automatic test_overflow();
    idle(); WE = 1; rw = 3; wd = 16'h01; step(); WE = 0;
    checks++; if (sp0 !== 8'h01) begin failures++; $display("FAIL sp_wr got=%h exp=01", sp0); end
    DecSP = 1; step();
    checks++; if ({sp0, ovf0} !== {8'h00, 1'b0}) begin failures++; $display("FAIL dec_to0 got=%h/%b exp=00/0", sp0, ovf0); end
    step();
    checks++; if ({sp0, ovf0} !== {8'h00, 1'b1}) begin failures++; $display("FAIL ovf_set got=%h/%b exp=00/1", sp0, ovf0); end
    clr_flags = 1; step();
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL set_beats_clr got=%b exp=1", ovf0); end
    DecSP = 0; step(); clr_flags = 0;
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf0); end
  endtask

  task automatic test_collision();
    idle(); WE = 1; rw = 3; wd = 16'h80; step();
    wd = 16'h40; DecSP = 1; step();
    checks++; if ({sp0, ovf0, unf0} !== {8'h40, 2'b00}) begin failures++; $display("FAIL spwr_dec got=%h/%b%b exp=40/00", sp0, ovf0, unf0); end
    rw = 1; wd = 16'h11; rb = 1; step();
    checks++; if (b0 !== 8'h11) begin failures++; $display("FAIL r1_wr got=%h exp=11", b0); end
    checks++; if (sp0 !== 8'h3F) begin failures++; $display("FAIL par_dec got=%h exp=3f", sp0); end
    WE = 0; IncSP = 1; step();
    checks++; if ({sp0, ovf0, unf0} !== {8'h3F, 2'b00}) begin failures++; $display("FAIL inc_dec got=%h/%b%b exp=3f/00", sp0, ovf0, unf0); end
    idle();
  endtask

  task automatic test_bypass();
    idle(); WE = 1; rw = 2; wd = 16'h77; ra = 2; #1;
    checks++; if (a1 !== 8'h77) begin failures++; $display("FAIL byp_on got=%h exp=77", a1); end
    checks++; if (a0 !== 8'h00) begin failures++; $display("FAIL byp_off_old got=%h exp=00", a0); end
    step();
    checks++; if (a0 !== 8'h77) begin failures++; $display("FAIL byp_off_new got=%h exp=77", a0); end
    rw = 3; wd = 16'h99; ra = 3; #1;
    checks++; if (a1 !== 8'h99) begin failures++; $display("FAIL byp_sp_rd got=%h exp=99", a1); end
    checks++; if (sp1 !== 8'h3F) begin failures++; $display("FAIL byp_spout got=%h exp=3f", sp1); end
    checks++; if (a0 !== 8'h3F) begin failures++; $display("FAIL nb_sp_rd got=%h exp=3f", a0); end
    step(); WE = 0;
    checks++; if ({sp0, sp1} !== 16'h9999) begin failures++; $display("FAIL sp_after got=%h/%h exp=99/99", sp0, sp1); end
  endtask

  task automatic test_sweep();
    logic [15:0] v;
    idle(); #2 rst = 1; #1;
    checks++; if (sp2 !== 16'h01FF) begin failures++; $display("FAIL w16_rst got=%h exp=01ff", sp2); end
    #1 rst = 0; step();
    DecSP = 1; repeat (255) step();
    checks++; if ({sp2, ovf2} !== {16'h0100, 1'b0}) begin failures++; $display("FAIL w16_min got=%h/%b exp=0100/0", sp2, ovf2); end
    step(); DecSP = 0;
    checks++; if ({sp2, ovf2} !== {16'h0100, 1'b1}) begin failures++; $display("FAIL w16_ovf got=%h/%b exp=0100/1", sp2, ovf2); end
    WE = 1;
    for (int i = 0; i < 8; i++) begin
      rw = 3'(i); wd = 16'hA000 | (16'(i) * 16'h0101); step();
    end
    WE = 0;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i); #1;
      v = 16'hA000 | (16'(i) * 16'h0101);
      checks++; if (a2 !== v) begin failures++; $display("FAIL w16_rda[%0d] got=%h exp=%h", i, a2, v); end
      v = 16'hA000 | (16'(7 - i) * 16'h0101);
      checks++; if (b2 !== v) begin failures++; $display("FAIL w16_rdb[%0d] got=%h exp=%h", 7 - i, b2, v); end
    end
    checks++; if (sp2 !== 16'hA707) begin failures++; $display("FAIL w16_spwr got=%h exp=a707", sp2); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_collision();
    test_bypass();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
